// File: rtl/execute_shift_pipe_pkg.sv
// Shared instruction definitions for the shift execute unit: opcode encodings,
// operand field widths and the internal shift-mode decode.
package execute_shift_pipe_pkg;

  localparam int LEN_OPECODE = 6;
  localparam int LEN_IMMF    = 1;
  localparam int LEN_IMM_EX  = 16;

  localparam logic [LEN_OPECODE-1:0] OPECODE_SHL = 6'h10;
  localparam logic [LEN_OPECODE-1:0] OPECODE_SHR = 6'h11;
  localparam logic [LEN_OPECODE-1:0] OPECODE_ASH = 6'h12;
  localparam logic [LEN_OPECODE-1:0] OPECODE_ROL = 6'h13;
  localparam logic [LEN_OPECODE-1:0] OPECODE_ROR = 6'h14;

  typedef enum logic [2:0] {
    MODE_SHL,
    MODE_SHR,
    MODE_ASH,
    MODE_ROL,
    MODE_ROR
  } shift_mode_t;

  function automatic logic opecode_legal(input logic [LEN_OPECODE-1:0] op);
    logic legal;
    case (op)
      OPECODE_SHL, OPECODE_SHR, OPECODE_ASH, OPECODE_ROL, OPECODE_ROR: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic shift_mode_t opecode_mode(input logic [LEN_OPECODE-1:0] op);
    shift_mode_t mode;
    case (op)
      OPECODE_SHR: mode = MODE_SHR;
      OPECODE_ASH: mode = MODE_ASH;
      OPECODE_ROL: mode = MODE_ROL;
      OPECODE_ROR: mode = MODE_ROR;
      default:     mode = MODE_SHL;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/execute_shift_pipe_shift_level.sv
// One barrel-shifter level: shifts or rotates by a fixed power-of-two STEP
// when enabled, otherwise passes the operand through.
module shift_level
  import execute_shift_pipe_pkg::*;
#(
  parameter int LEN_REG = 32,
  parameter int STEP    = 1
) (
  input  logic [LEN_REG-1:0] i_data,
  input  logic               i_en,
  input  shift_mode_t        i_mode,
  output logic [LEN_REG-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_mode)
        MODE_SHL: o_data = i_data << STEP;
        MODE_SHR: o_data = i_data >> STEP;
        MODE_ASH: o_data = $signed(i_data) >>> STEP;
        MODE_ROL: o_data = (i_data << STEP) | (i_data >> (LEN_REG - STEP));
        MODE_ROR: o_data = (i_data >> STEP) | (i_data << (LEN_REG - STEP));
        default:  o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/execute_shift_pipe.sv
// Pipelined shift/rotate execute unit: barrel levels spread over NUM_STAGES
// register stages with valid/ready handshakes and bubble collapsing.
module execute_shift_pipe
  import execute_shift_pipe_pkg::*;
#(
  parameter int LEN_REG    = 32,
  parameter int NUM_STAGES = 2,
  parameter int LEN_TAG    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LEN_OPECODE-1:0] opecode,
  input  logic [LEN_IMMF-1:0]    immf,
  input  logic [LEN_REG-1:0]     data_rd,
  input  logic [LEN_REG-1:0]     data_rs,
  input  logic [LEN_IMM_EX-1:0]  imm_ex,
  input  logic [LEN_TAG-1:0]     tag_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LEN_REG-1:0]     data_o,
  output logic [LEN_TAG-1:0]     tag_o,
  output logic                   err_o
);

  localparam int LEN_SH = $clog2(LEN_REG);

  logic [NUM_STAGES-1:0] w_valid_vec;
  logic [NUM_STAGES-1:0] w_ld;
  logic [LEN_SH-1:0]     w_in_sh;
  logic                  w_in_err;
  logic                  w_unused;

  assign w_in_err = !opecode_legal(opecode);
  assign w_in_sh  = (|immf) ? imm_ex[LEN_SH-1:0] : data_rs[LEN_SH-1:0];
  assign w_unused = ^{data_rs[LEN_REG-1:LEN_SH], imm_ex[LEN_IMM_EX-1:LEN_SH]};

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      // Levels [LVL_LO, LVL_HI) belong to this stage, ascending and evenly split.
      localparam int LVL_LO = (gi * LEN_SH) / NUM_STAGES;
      localparam int LVL_HI = ((gi + 1) * LEN_SH) / NUM_STAGES;

      logic               w_vld;
      logic [LEN_REG-1:0] w_data;
      logic [LEN_SH-1:0]  w_sh;
      shift_mode_t        w_mode;
      logic [LEN_TAG-1:0] w_tag;
      logic               w_err;
      logic [LEN_REG-1:0] w_res;
      logic               w_unused_sh;

      logic               r_valid;
      logic [LEN_REG-1:0] r_data;
      logic [LEN_TAG-1:0] r_tag;
      logic               r_err;

      if (gi == 0) begin : g_head
        // Illegal opcodes travel as a zero operand, which every mode keeps at zero.
        assign w_vld  = in_valid;
        assign w_data = w_in_err ? '0 : data_rd;
        assign w_sh   = w_in_sh;
        assign w_mode = opecode_mode(opecode);
        assign w_tag  = tag_i;
        assign w_err  = w_in_err;
      end else begin : g_link
        assign w_vld  = g_stage[gi-1].r_valid;
        assign w_data = g_stage[gi-1].r_data;
        assign w_sh   = g_stage[gi-1].g_fwd.r_sh;
        assign w_mode = g_stage[gi-1].g_fwd.r_mode;
        assign w_tag  = g_stage[gi-1].r_tag;
        assign w_err  = g_stage[gi-1].r_err;
      end
      assign w_unused_sh = ^w_sh;

      for (gj = LVL_LO; gj < LVL_HI; gj++) begin : g_lvl
        logic [LEN_REG-1:0] w_in;
        logic [LEN_REG-1:0] w_out;
        if (gj == LVL_LO) begin : g_first
          assign w_in = w_data;
        end else begin : g_chain
          assign w_in = g_lvl[gj-1].w_out;
        end
        shift_level #(
          .LEN_REG (LEN_REG),
          .STEP    (1 << gj)
        ) u_level (
          .i_data (w_in),
          .i_en   (w_sh[gj]),
          .i_mode (w_mode),
          .o_data (w_out)
        );
      end
      assign w_res = g_lvl[LVL_HI-1].w_out;

      // A stage may load iff some stage at or after it is empty, or the tail drains.
      assign w_valid_vec[gi] = r_valid;
      assign w_ld[gi]        = out_ready || !(&w_valid_vec[NUM_STAGES-1:gi]);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_tag   <= '0;
          r_err   <= 1'b0;
        end else if (w_ld[gi]) begin
          r_valid <= w_vld;
          if (w_vld) begin
            r_data <= w_res;
            r_tag  <= w_tag;
            r_err  <= w_err;
          end
        end
      end

      if (gi < NUM_STAGES - 1) begin : g_fwd
        logic [LEN_SH-1:0] r_sh;
        shift_mode_t       r_mode;
        always_ff @(posedge clk) begin
          if (rst) begin
            r_sh   <= '0;
            r_mode <= MODE_SHL;
          end else if (w_ld[gi] && w_vld) begin
            r_sh   <= w_sh;
            r_mode <= w_mode;
          end
        end
      end
    end
  endgenerate

  // Equivalent to !valid[0] || advance[0]; depends only on state and out_ready.
  assign in_ready  = w_ld[0];
  assign out_valid = g_stage[NUM_STAGES-1].r_valid;
  assign data_o    = g_stage[NUM_STAGES-1].r_data;
  assign tag_o     = g_stage[NUM_STAGES-1].r_tag;
  assign err_o     = g_stage[NUM_STAGES-1].r_err;

endmodule

// File: tb/tb_execute_shift_pipe.sv
// Self-checking bench: directed vector table, handshake corner sequences and a
// randomized sweep over four width/depth configurations against a reference model.
module tb_execute_shift_pipe;
  import execute_shift_pipe_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic        im;
    logic [31:0] rd;
    logic [31:0] rs;
    logic [15:0] imm;
    logic [4:0]  tag;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  localparam int WID [4] = '{32, 8, 64, 64};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  opecode;
  logic [0:0]  immf;
  logic [63:0] data_rd, data_rs;
  logic [15:0] imm_ex;
  logic [4:0]  tag_i;
  logic        out_ready;

  logic        in_ready_m, out_valid_m, err_o_m;
  logic [31:0] data_o_m;
  logic [4:0]  tag_o_m;
  logic        in_ready_b, out_valid_b, err_o_b;
  logic [7:0]  data_o_b;
  logic [4:0]  tag_o_b;
  logic        in_ready_c, out_valid_c, err_o_c;
  logic [63:0] data_o_c;
  logic [4:0]  tag_o_c;
  logic        in_ready_d, out_valid_d, err_o_d;
  logic [63:0] data_o_d;
  logic [4:0]  tag_o_d;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb [4][$];

  always #5 clk = ~clk;

  execute_shift_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .opecode(opecode),
    .immf(immf), .data_rd(data_rd[31:0]), .data_rs(data_rs[31:0]), .imm_ex(imm_ex),
    .tag_i(tag_i), .out_valid(out_valid_m), .out_ready(out_ready), .data_o(data_o_m),
    .tag_o(tag_o_m), .err_o(err_o_m)
  );

  execute_shift_pipe #(.LEN_REG(8), .NUM_STAGES(3)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .opecode(opecode),
    .immf(immf), .data_rd(data_rd[7:0]), .data_rs(data_rs[7:0]), .imm_ex(imm_ex),
    .tag_i(tag_i), .out_valid(out_valid_b), .out_ready(1'b1), .data_o(data_o_b),
    .tag_o(tag_o_b), .err_o(err_o_b)
  );

  execute_shift_pipe #(.LEN_REG(64), .NUM_STAGES(1)) u_dut64a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .opecode(opecode),
    .immf(immf), .data_rd(data_rd), .data_rs(data_rs), .imm_ex(imm_ex),
    .tag_i(tag_i), .out_valid(out_valid_c), .out_ready(1'b1), .data_o(data_o_c),
    .tag_o(tag_o_c), .err_o(err_o_c)
  );

  execute_shift_pipe #(.LEN_REG(64), .NUM_STAGES(6)) u_dut64b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d), .opecode(opecode),
    .immf(immf), .data_rd(data_rd), .data_rs(data_rs), .imm_ex(imm_ex),
    .tag_i(tag_i), .out_valid(out_valid_d), .out_ready(1'b1), .data_o(data_o_d),
    .tag_o(tag_o_d), .err_o(err_o_d)
  );

  // Reference: plain wide arithmetic on a w-bit operand.
  function automatic exp_t ref_op(input int w, input logic [5:0] op, input logic im,
                                  input logic [63:0] rd, input logic [63:0] rs,
                                  input logic [15:0] imm, input logic [4:0] t);
    logic [127:0] m, d, r;
    logic [63:0]  sel;
    int           sh;
    exp_t         e;
    m   = (128'd1 << w) - 128'd1;
    d   = {64'd0, rd} & m;
    sel = im ? {48'd0, imm} : rs;
    sh  = int'(sel % 64'(w));
    e.err = 1'b0;
    case (op)
      OPECODE_SHL: r = (d << sh) & m;
      OPECODE_SHR: r = d >> sh;
      OPECODE_ASH: begin
        if (d[w-1]) d = d | ~m;
        r = (d >> sh) & m;
      end
      OPECODE_ROL: r = ((d << sh) | (d >> (w - sh))) & m;
      OPECODE_ROR: r = ((d >> sh) | (d << (w - sh))) & m;
      default: begin
        r = '0;
        e.err = 1'b1;
      end
    endcase
    e.data = r[63:0];
    e.tag  = t;
    return e;
  endfunction

  // Scoreboard: handshakes are evaluated at the falling edge, inputs change after rising edges.
  always @(negedge clk) begin : mon
    logic        vld  [4];
    logic        ir   [4];
    logic        ordy [4];
    logic [63:0] dat  [4];
    logic [4:0]  tg   [4];
    logic        er   [4];
    logic        prev_stall [4];
    logic [63:0] prev_dat   [4];
    logic [4:0]  prev_tg    [4];
    logic        prev_er    [4];
    exp_t        e;
    vld  = '{out_valid_m, out_valid_b, out_valid_c, out_valid_d};
    ir   = '{in_ready_m, in_ready_b, in_ready_c, in_ready_d};
    ordy = '{out_ready, 1'b1, 1'b1, 1'b1};
    dat  = '{{32'd0, data_o_m}, {56'd0, data_o_b}, data_o_c, data_o_d};
    tg   = '{tag_o_m, tag_o_b, tag_o_c, tag_o_d};
    er   = '{err_o_m, err_o_b, err_o_c, err_o_d};
    for (int k = 0; k < 4; k++) begin
      if (prev_stall[k] === 1'b1) begin
        n_checks++;
        if (!vld[k] || dat[k] !== prev_dat[k] || tg[k] !== prev_tg[k] || er[k] !== prev_er[k]) begin
          n_fail++;
          $display("FAIL sb%0d_hold: got valid=%0d data=%h tag=%0d, required data=%h tag=%0d held",
                   k, vld[k], dat[k], tg[k], prev_dat[k], prev_tg[k]);
        end
      end
      if (rst) begin
        sb[k].delete();
      end else begin
        if (vld[k] && ordy[k]) begin
          n_checks++;
          if (sb[k].size() == 0) begin
            n_fail++;
            $display("FAIL sb%0d_unexpected: got data=%h tag=%0d, required no output", k, dat[k], tg[k]);
          end else begin
            e = sb[k].pop_front();
            if (dat[k] !== e.data || tg[k] !== e.tag || er[k] !== e.err) begin
              n_fail++;
              $display("FAIL sb%0d_result: got data=%h tag=%0d err=%0d, required data=%h tag=%0d err=%0d",
                       k, dat[k], tg[k], er[k], e.data, e.tag, e.err);
            end
          end
        end
        if (in_valid && ir[k])
          sb[k].push_back(ref_op(WID[k], opecode, immf[0], data_rd, data_rs, imm_ex, tag_i));
      end
      prev_stall[k] = vld[k] && !ordy[k] && !rst;
      prev_dat[k]   = dat[k];
      prev_tg[k]    = tg[k];
      prev_er[k]    = er[k];
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] op, input logic im, input logic [63:0] rd,
                        input logic [63:0] rs, input logic [15:0] imm, input logic [4:0] t);
    opecode = op; immf = im; data_rd = rd; data_rs = rs; imm_ex = imm; tag_i = t;
  endtask

  task automatic set_rand(input logic [4:0] t, input bit allow_bad);
    logic [5:0] op;
    case ($urandom_range(0, 4))
      0: op = OPECODE_SHL;
      1: op = OPECODE_SHR;
      2: op = OPECODE_ASH;
      3: op = OPECODE_ROL;
      default: op = OPECODE_ROR;
    endcase
    if (allow_bad && $urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
    set_op(op, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
           16'($urandom), t);
  endtask

  vec_t vecs [11];

  initial begin
    int lat, cur, acc_cnt, first_c, last_c, c;
    logic got_out, acc, have_snap;
    logic [31:0] snap_d;
    logic [4:0]  snap_t;
    int seen[$];

    vecs[0]  = '{OPECODE_ASH, 1'b1, 32'h80000000, 32'h0000001F, 16'h0004, 5'd1, 32'hF8000000, 1'b0};
    vecs[1]  = '{OPECODE_ROL, 1'b0, 32'h80000001, 32'h00000021, 16'h0005, 5'd2, 32'h00000003, 1'b0};
    vecs[2]  = '{OPECODE_ROR, 1'b0, 32'h80000001, 32'h00000021, 16'h0005, 5'd4, 32'hC0000000, 1'b0};
    vecs[3]  = '{6'h3F,       1'b0, 32'hDEADBEEF, 32'h00000004, 16'h0000, 5'd3, 32'h00000000, 1'b1};
    vecs[4]  = '{OPECODE_SHL, 1'b0, 32'h000000FF, 32'h00000008, 16'h0001, 5'd5, 32'h0000FF00, 1'b0};
    vecs[5]  = '{OPECODE_SHR, 1'b1, 32'hF0000000, 32'h00000001, 16'h003C, 5'd6, 32'h0000000F, 1'b0};
    vecs[6]  = '{OPECODE_ASH, 1'b0, 32'h40000000, 32'h0000001E, 16'h0000, 5'd7, 32'h00000001, 1'b0};
    vecs[7]  = '{OPECODE_SHL, 1'b0, 32'h12345678, 32'h00000020, 16'h0003, 5'd8, 32'h12345678, 1'b0};
    vecs[8]  = '{OPECODE_ROR, 1'b0, 32'h12345678, 32'h0000001F, 16'h0000, 5'd9, 32'h2468ACF0, 1'b0};
    vecs[9]  = '{OPECODE_SHL, 1'b1, 32'hFFFFFFFF, 32'h00000000, 16'h001F, 5'd10, 32'h80000000, 1'b0};
    vecs[10] = '{OPECODE_ASH, 1'b1, 32'h80000000, 32'h00000000, 16'hFFFF, 5'd11, 32'hFFFFFFFF, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_op(6'd0, 1'b0, 64'd0, 64'd0, 16'd0, 5'd0);
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid_m), 64'd0);
    chk("reset_in_ready", 64'(in_ready_m), 64'd1);
    chk("reset_data_o", 64'(data_o_m), 64'd0);
    chk("reset_tag_o", 64'(tag_o_m), 64'd0);
    chk("reset_err_o", 64'(err_o_m), 64'd0);

    // Directed vectors, one at a time through an idle pipeline.
    for (int i = 0; i < 11; i++) begin
      step();
      set_op(vecs[i].op, vecs[i].im, 64'(vecs[i].rd), 64'(vecs[i].rs), vecs[i].imm, vecs[i].tag);
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready_m), 64'd1);
      step();
      in_valid = 1'b0;
      lat = 0; got_out = 1'b0;
      while (lat < 20 && !got_out) begin
        @(negedge clk);
        lat++;
        if (out_valid_m) got_out = 1'b1;
      end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_data", i), 64'(data_o_m), 64'(vecs[i].exp_d));
      chk($sformatf("vec%0d_tag", i), 64'(tag_o_m), 64'(vecs[i].tag));
      chk($sformatf("vec%0d_err", i), 64'(err_o_m), 64'(vecs[i].exp_e));
    end
    repeat (4) step();

    // Eight back-to-back operations with the output always ready.
    first_c = -1; last_c = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k < 8) begin
        set_rand(5'(k), 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid_m) begin
        seen.push_back(int'(tag_o_m));
        if (first_c < 0) first_c = k;
        last_c = k;
      end
    end
    chk("b2b_count", 64'(seen.size()), 64'd8);
    chk("b2b_consecutive", 64'(last_c - first_c), 64'd7);
    for (int k = 0; k < seen.size(); k++) chk($sformatf("b2b_tag%0d", k), 64'(seen[k]), 64'(k));

    // Stall: out_ready low for five cycles with continuous input.
    seen.delete();
    out_ready = 1'b0; cur = 0; acc_cnt = 0; have_snap = 1'b0;
    step();
    set_rand(5'd10, 1'b0);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      acc = in_valid && in_ready_m;
      if (acc) acc_cnt++;
      if (out_valid_m) begin
        if (!have_snap) begin
          snap_d = data_o_m; snap_t = tag_o_m; have_snap = 1'b1;
        end else begin
          chk($sformatf("stall_data_c%0d", k), 64'(data_o_m), 64'(snap_d));
          chk($sformatf("stall_tag_c%0d", k), 64'(tag_o_m), 64'(snap_t));
        end
      end
      step();
      if (acc) begin
        cur++;
        set_rand(5'(10 + cur), 1'b0);
      end
    end
    chk("stall_accepted", 64'(acc_cnt), 64'd2);
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready_m), 64'd0);
    step();
    out_ready = 1'b1;
    c = 0;
    while (seen.size() < 6 && c < 40) begin
      @(negedge clk);
      acc = in_valid && in_ready_m;
      if (out_valid_m) seen.push_back(int'(tag_o_m));
      step();
      if (acc) begin
        cur++;
        if (cur < 6) set_rand(5'(10 + cur), 1'b0);
        else in_valid = 1'b0;
      end
      c++;
    end
    in_valid = 1'b0;
    chk("release_count", 64'(seen.size()), 64'd6);
    for (int k = 0; k < seen.size(); k++) chk($sformatf("release_tag%0d", k), 64'(seen[k]), 64'(10 + k));
    repeat (4) step();

    // Reset with two operations in flight; the input offered during reset is refused.
    out_ready = 1'b0;
    set_rand(5'd20, 1'b0); in_valid = 1'b1;
    step();
    set_rand(5'd21, 1'b0);
    step();
    out_ready = 1'b1; rst = 1'b1;
    set_rand(5'd22, 1'b0);
    @(negedge clk);
    chk("rst_inflight_valid", 64'(out_valid_m), 64'd1);
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_m), 64'd0);
    chk("rst_in_ready", 64'(in_ready_m), 64'd1);
    chk("rst_data_o", 64'(data_o_m), 64'd0);
    chk("rst_tag_o", 64'(tag_o_m), 64'd0);
    chk("rst_err_o", 64'(err_o_m), 64'd0);
    c = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      if (out_valid_m || out_valid_b || out_valid_c || out_valid_d) c++;
    end
    chk("rst_none_emerge", 64'(c), 64'd0);

    // Randomized sweep; the scoreboard checks all four configurations.
    for (int k = 0; k < 600; k++) begin
      step();
      if ($urandom_range(0, 9) < 7) begin
        set_rand(5'(k), 1'b1);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) step();
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("drain_sb%0d", k), 64'(sb[k].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_shift_pipe.md
EXECUTE_SHIFT_PIPE -- requirements
Module: execute_shift_pipe

Interface
REQ-001 SHALL have parameter LEN_REG, default 32: operand/result width; power of two, 8..64.
REQ-002 SHALL have parameter NUM_STAGES, default 2: pipeline register stages, 1..log2(LEN_REG).
REQ-003 SHALL have parameter LEN_TAG, default 5: sideband tag width (destination register index).
REQ-004 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have ports in_valid in 1 and in_ready out 1: input handshake.
REQ-007 SHALL have port opecode  in  LEN_OPECODE: selects SHL, SHR, ASH, ROL or ROR.
REQ-008 SHALL have ports immf in LEN_IMMF, data_rd in LEN_REG, data_rs in LEN_REG, imm_ex in LEN_IMM_EX: operands.
REQ-009 SHALL have port tag_i  in  LEN_TAG: carried unchanged to tag_o.
REQ-010 SHALL have ports out_valid out 1 and out_ready in 1: output handshake.
REQ-011 SHALL have ports data_o out LEN_REG, tag_o out LEN_TAG, err_o out 1 (illegal opecode).

Function
REQ-012 Shift amount SHALL be sh = low log2(LEN_REG) bits of data_rs when immf==0, else of imm_ex; upper bits ignored.
REQ-013 SHL SHALL yield data_rd << sh, zero fill.
REQ-014 SHR SHALL yield data_rd >> sh, zero fill.
REQ-015 ASH SHALL yield arithmetic right shift of data_rd by sh, replicating data_rd[LEN_REG-1].
REQ-016 ROL/ROR SHALL rotate data_rd left/right by sh; sh==0 returns data_rd unchanged for every op.
REQ-017 Any other opecode SHALL yield data_o=0 with err_o=1; err_o=0 otherwise.
REQ-018 Transfer in SHALL occur on a cycle with in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-019 Barrel levels (1,2,4,...) SHALL be split across NUM_STAGES register stages, level-to-stage assignment in ascending order, levels distributed as evenly as possible.
REQ-020 Latency SHALL be exactly NUM_STAGES cycles from input transfer to out_valid with an unstalled pipeline.
REQ-021 Each stage SHALL hold a valid bit; a stage SHALL load when it is empty or its contents are transferred onward in the same cycle (bubble collapsing).
REQ-022 in_ready SHALL equal !valid[0] || advance[0], combinationally; no combinational path from in_valid to in_ready.
REQ-023 Throughput SHALL be one operation per cycle while out_ready==1 continuously.
REQ-024 With out_ready==0, the pipeline SHALL fill to NUM_STAGES entries, then deassert in_ready; no entry lost or duplicated.
REQ-025 data_o, tag_o, err_o SHALL be held stable while out_valid && !out_ready.
REQ-026 Results SHALL leave in input order; tag_o matches the tag_i of the same operation.

Reset
REQ-027 rst==1 SHALL clear all stage valid bits on the next clock edge, discarding in-flight operations, including mid-stall.
REQ-028 After reset: out_valid=0, in_ready=1, data_o=0, tag_o=0, err_o=0.
REQ-029 in_valid during a reset cycle SHALL NOT be accepted.

Structure
REQ-030 OPECODE_SHL/SHR/ASH/ROL/ROR, LEN_OPECODE, LEN_IMMF, LEN_IMM_EX SHALL come from the shared instruction definitions; OPECODE_ROL/ROR added there.
REQ-031 One sub-module, shift_level, SHALL implement one barrel level (fixed power-of-two step, all five modes), instantiated log2(LEN_REG) times.
REQ-032 Stage valid/advance logic SHALL be generated from NUM_STAGES, no per-value special cases.

Verification
REQ-033 LEN_REG=32, NUM_STAGES=2: ASH data_rd=0x80000000, immf=1, imm_ex=4 -> data_o=0xF8000000 after 2 cycles.
REQ-034 ROL data_rd=0x80000001, data_rs=0x21 (sh=1) -> 0x00000003; ROR same inputs -> 0xC0000000.
REQ-035 Back-to-back 8 ops, out_ready=1 -> 8 consecutive out_valid cycles, tags 0..7 in order.
REQ-036 out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 accepted, in_ready=0 afterwards, outputs stable; release -> both delivered, then resume.
REQ-037 Illegal opecode, tag 3 -> data_o=0, err_o=1, tag_o=3; rst asserted with 2 ops in flight -> out_valid=0 next cycle, none emerge.
REQ-038 Randomised sweep, LEN_REG in {8,32,64}, NUM_STAGES in {1,log2(LEN_REG)}, compared against a reference model.
